// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared constants, FSM encodings and helpers for the AXI4-lite SRAM target.
// Default window: 1024 words starting at 0x8000_0000.
package axi_lite_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned SRAM_DEPTH_DEFAULT = 1024;
  localparam logic [31:0] SRAM_ADDR_BEGIN    = 32'h8000_0000;
  // Last byte address inside the default window.
  localparam logic [31:0] SRAM_ADDR_END      = SRAM_ADDR_BEGIN + 32'(4 * SRAM_DEPTH_DEFAULT) - 32'd1;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  function automatic logic [1:0] decode_resp(input logic hit);
    return hit ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi_sram_store.sv
// Word-organised storage: one synchronous byte-masked write port and one
// combinational read port.
module axi_sram_store #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  parameter  int unsigned DATA_WIDTH  = 32,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS),
  localparam int unsigned STRB_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_widx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  input  logic [IDX_W-1:0]      i_ridx,
  output logic [DATA_WIDTH-1:0] o_rd
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset so it maps onto plain SRAM/LUT-RAM; contents
  // are undefined until written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rd = r_mem[i_ridx];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-lite SRAM target: independent read and write FSMs with programmable
// response latency and DECERR for addresses outside the decoded window.
module axi_lite_sram_slave
  import axi_lite_sram_slave_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = SRAM_DEPTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = SRAM_ADDR_BEGIN,
  parameter int unsigned           RD_LATENCY  = 2,
  parameter int unsigned           WR_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    aready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [DATA_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  output logic [1:0]              bresp,
  input  logic                    bready
);

  localparam int unsigned           IDX_W       = $clog2(DEPTH_WORDS);
  localparam int unsigned           STRB_W      = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] SPAN        = DATA_WIDTH'(4 * DEPTH_WORDS);
  localparam logic [LAT_W-1:0]      RD_CNT_INIT = LAT_W'(RD_LATENCY);
  localparam logic [LAT_W-1:0]      WR_CNT_INIT = LAT_W'(WR_LATENCY);

  rd_state_e             r_rd_state;
  logic [LAT_W-1:0]      r_rd_cnt;
  logic [DATA_WIDTH-1:0] r_araddr;
  logic                  r_aready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  wr_state_e             r_wr_state;
  logic [LAT_W-1:0]      r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_awaddr, r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_aw_done, r_w_done;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;

  // With zero latency the response is formed on the handshake edge itself,
  // so decode must look at the live bus rather than the latched copy.
  logic [DATA_WIDTH-1:0] w_rd_addr, w_rd_off, w_store_rd, w_rd_data;
  logic                  w_rd_hit;
  logic [1:0]            w_rd_resp;

  assign w_rd_addr = (r_rd_state == R_IDLE) ? araddr : r_araddr;
  assign w_rd_off  = w_rd_addr - BASE_ADDR;
  assign w_rd_hit  = (w_rd_addr >= BASE_ADDR) && (w_rd_off < SPAN);
  assign w_rd_data = w_rd_hit ? w_store_rd : '0;
  assign w_rd_resp = decode_resp(w_rd_hit);

  logic                  w_aw_hs, w_w_hs, w_wr_both, w_wr_commit, w_wr_hit, w_store_we;
  logic [DATA_WIDTH-1:0] w_wr_addr, w_wr_off, w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [1:0]            w_wr_resp;

  assign w_aw_hs   = awvalid && r_awready;
  assign w_w_hs    = wvalid && r_wready;
  assign w_wr_both = (r_wr_state == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_wr_addr = r_aw_done ? r_awaddr : awaddr;
  assign w_wr_data = r_w_done ? r_wdata : wdata;
  assign w_wr_strb = r_w_done ? r_wstrb : wstrb;
  assign w_wr_off  = w_wr_addr - BASE_ADDR;
  assign w_wr_hit  = (w_wr_addr >= BASE_ADDR) && (w_wr_off < SPAN);
  assign w_wr_resp = decode_resp(w_wr_hit);

  assign w_wr_commit = ((r_wr_state == W_WAIT) && (r_wr_cnt == LAT_W'(1)))
                    || (w_wr_both && (WR_LATENCY == 0));
  // A reset on the commit edge cancels the write along with the transaction.
  assign w_store_we  = w_wr_commit && w_wr_hit && resetn;

  axi_sram_store #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_widx  (w_wr_off[IDX_W+1:2]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_ridx  (w_rd_off[IDX_W+1:2]),
    .o_rd    (w_store_rd)
  );

  // NOTE: all state below uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_araddr   <= '0;
      r_aready   <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (arvalid && r_aready) begin
            r_araddr <= araddr;
            r_aready <= 1'b0;
            if (RD_LATENCY == 0) begin
              r_rd_state <= R_RESP;
              r_rvalid   <= 1'b1;
              r_rdata    <= w_rd_data;
              r_rresp    <= w_rd_resp;
            end else begin
              r_rd_state <= R_WAIT;
              r_rd_cnt   <= RD_CNT_INIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rd_cnt == LAT_W'(1)) begin
            r_rd_state <= R_RESP;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
          end else begin
            r_rd_cnt <= r_rd_cnt - LAT_W'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rvalid   <= 1'b0;
            r_aready   <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= awaddr;
            r_aw_done <= 1'b1;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
            r_w_done <= 1'b1;
            r_wready <= 1'b0;
          end
          if (w_wr_both) begin
            if (WR_LATENCY == 0) begin
              r_wr_state <= W_RESP;
              r_bvalid   <= 1'b1;
              r_bresp    <= w_wr_resp;
            end else begin
              r_wr_state <= W_WAIT;
              r_wr_cnt   <= WR_CNT_INIT;
            end
          end
        end
        W_WAIT: begin
          if (r_wr_cnt == LAT_W'(1)) begin
            r_wr_state <= W_RESP;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_wr_resp;
          end else begin
            r_wr_cnt <= r_wr_cnt - LAT_W'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign aready  = r_aready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: a latency-2 instance for most steps
// and a latency-0 instance exercised at the end through the same bus.
module tb_axi_lite_sram_slave;

  logic        clk;
  logic        resetn_a, resetn_z, sel;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;

  logic        a_aready, a_rvalid, a_awready, a_wready, a_bvalid;
  logic [31:0] a_rdata;
  logic [1:0]  a_rresp, a_bresp;
  logic        z_aready, z_rvalid, z_awready, z_wready, z_bvalid;
  logic [31:0] z_rdata;
  logic [1:0]  z_rresp, z_bresp;

  logic        t_aready, t_rvalid, t_awready, t_wready, t_bvalid;
  logic [31:0] t_rdata;
  logic [1:0]  t_rresp, t_bresp;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_sram_slave #(.RD_LATENCY(2), .WR_LATENCY(2)) dut (
    .clk(clk), .resetn(resetn_a),
    .araddr(araddr), .arvalid(arvalid), .aready(a_aready),
    .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(a_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(a_wready),
    .bvalid(a_bvalid), .bresp(a_bresp), .bready(bready)
  );

  axi_lite_sram_slave #(.RD_LATENCY(0), .WR_LATENCY(0)) dut_lat0 (
    .clk(clk), .resetn(resetn_z),
    .araddr(araddr), .arvalid(arvalid), .aready(z_aready),
    .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(z_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(z_wready),
    .bvalid(z_bvalid), .bresp(z_bresp), .bready(bready)
  );

  assign t_aready  = sel ? z_aready  : a_aready;
  assign t_rvalid  = sel ? z_rvalid  : a_rvalid;
  assign t_rdata   = sel ? z_rdata   : a_rdata;
  assign t_rresp   = sel ? z_rresp   : a_rresp;
  assign t_awready = sel ? z_awready : a_awready;
  assign t_wready  = sel ? z_wready  : a_wready;
  assign t_bvalid  = sel ? z_bvalid  : a_bvalid;
  assign t_bresp   = sel ? z_bresp   : a_bresp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one read; lat counts cycles from the AR handshake to the first rvalid.
  task automatic rd(input logic [31:0] addr, output int lat,
                    output logic [31:0] data, output logic [1:0] resp);
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    check("rd_aready", {31'd0, t_aready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!t_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data   = t_rdata;
    resp   = t_rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Issue one write with AW and W in the same cycle.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output int lat, output logic [1:0] resp);
    @(negedge clk);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    check("wr_ready", {30'd0, t_awready, t_wready}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    while (!t_bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp   = t_bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          seen;
    logic [31:0] d;
    logic [1:0]  r;

    resetn_a = 1'b0; resetn_z = 1'b0; sel = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_aready",  {31'd0, t_aready},  32'd1);
    check("rst_awready", {31'd0, t_awready}, 32'd1);
    check("rst_wready",  {31'd0, t_wready},  32'd1);
    check("rst_rvalid",  {31'd0, t_rvalid},  32'd0);
    check("rst_bvalid",  {31'd0, t_bvalid},  32'd0);
    check("rst_rdata",   t_rdata,            32'd0);
    check("rst_rresp",   {30'd0, t_rresp},   32'd0);
    check("rst_bresp",   {30'd0, t_bresp},   32'd0);
    resetn_a = 1'b1;

    // Write then read back
    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, r);
    check("wr1_lat",  32'(lat), 32'd3);
    check("wr1_resp", {30'd0, r}, 32'd0);
    rd(32'h8000_0010, lat, d, r);
    check("rd1_lat",  32'(lat), 32'd3);
    check("rd1_data", d, 32'hDEAD_BEEF);
    check("rd1_resp", {30'd0, r}, 32'd0);

    // Byte strobes
    wr(32'h8000_0020, 32'h1122_3344, 4'hF, lat, r);
    wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, lat, r);
    check("strb_bresp", {30'd0, r}, 32'd0);
    rd(32'h8000_0020, lat, d, r);
    check("strb_data", d, 32'h11BB_33DD);

    // Decode errors; 0x8000_1000 would alias word 0 without the range check
    wr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, lat, r);
    rd(32'h7FFF_FFFC, lat, d, r);
    check("dec_rresp", {30'd0, r}, 32'd3);
    check("dec_rdata", d, 32'd0);
    check("dec_rlat",  32'(lat), 32'd3);
    wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, lat, r);
    check("dec_bresp", {30'd0, r}, 32'd3);
    rd(32'h8000_0000, lat, d, r);
    check("dec_word0", d, 32'h0BAD_F00D);

    // Zero strobe in range: OKAY, no change
    wr(32'h8000_0010, 32'h0000_0000, 4'h0, lat, r);
    check("strb0_bresp", {30'd0, r}, 32'd0);
    rd(32'h8000_0010, lat, d, r);
    check("strb0_data", d, 32'hDEAD_BEEF);

    // Read backpressure
    @(negedge clk);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!t_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", {31'd0, t_rvalid}, 32'd1);
      check("bp_rdata",  t_rdata, 32'h11BB_33DD);
      check("bp_rresp",  {30'd0, t_rresp}, 32'd0);
      check("bp_aready", {31'd0, t_aready}, 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("bp_done_rvalid", {31'd0, t_rvalid}, 32'd0);
    check("bp_done_aready", {31'd0, t_aready}, 32'd1);

    // rready high before rvalid: one-cycle response
    @(negedge clk);
    rready = 1'b1;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!t_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("early_lat",  32'(lat), 32'd3);
    check("early_data", t_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("early_rvalid_drop", {31'd0, t_rvalid}, 32'd0);
    rready = 1'b0;

    // AW/W skew: W in cycle 0, AW in cycle 4, bvalid in cycle 7
    @(negedge clk);
    wdata = 32'h5A5A_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("skew_wready", {31'd0, t_wready}, 32'd0);
      check("skew_bvalid", {31'd0, t_bvalid}, 32'd0);
      @(negedge clk);
    end
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    check("skew_awready", {31'd0, t_awready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    check("skew_c5_bvalid", {31'd0, t_bvalid}, 32'd0);
    @(negedge clk);
    check("skew_c6_bvalid", {31'd0, t_bvalid}, 32'd0);
    @(negedge clk);
    check("skew_c7_bvalid", {31'd0, t_bvalid}, 32'd1);
    check("skew_bresp", {30'd0, t_bresp}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("skew_idle_ready", {30'd0, t_awready, t_wready}, 32'd3);
    rd(32'h8000_0030, lat, d, r);
    check("skew_data", d, 32'h5A5A_A5A5);

    // Read response entry coinciding with the write commit returns old data
    wr(32'h8000_0040, 32'h0101_0101, 4'hF, lat, r);
    @(negedge clk);
    araddr = 32'h8000_0040; arvalid = 1'b1;
    awaddr = 32'h8000_0040; wdata = 32'h0202_0202; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!t_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("order_lat",    32'(lat), 32'd3);
    check("order_bvalid", {31'd0, t_bvalid}, 32'd1);
    check("order_old",    t_rdata, 32'h0101_0101);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    rd(32'h8000_0040, lat, d, r);
    check("order_new", d, 32'h0202_0202);

    // Reset during R_WAIT drops the read
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    resetn_a = 1'b0;
    @(negedge clk);
    check("rrst_rvalid", {31'd0, t_rvalid}, 32'd0);
    check("rrst_aready", {31'd0, t_aready}, 32'd1);
    resetn_a = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (t_rvalid) seen++;
    end
    check("rrst_no_resp", 32'(seen), 32'd0);

    // Reset on the would-be commit edge suppresses the write
    @(negedge clk);
    awaddr = 32'h8000_0010; wdata = 32'h0000_0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    resetn_a = 1'b0;
    @(negedge clk);
    check("wrst_bvalid",  {31'd0, t_bvalid}, 32'd0);
    check("wrst_awready", {31'd0, t_awready}, 32'd1);
    resetn_a = 1'b1;
    rd(32'h8000_0010, lat, d, r);
    check("wrst_data", d, 32'hDEAD_BEEF);

    // Zero-latency instance
    @(negedge clk);
    resetn_a = 1'b0;
    sel      = 1'b1;
    resetn_z = 1'b1;
    wr(32'h8000_0008, 32'hCAFE_F00D, 4'hF, lat, r);
    check("l0_wr_lat",  32'(lat), 32'd1);
    check("l0_wr_resp", {30'd0, r}, 32'd0);
    rd(32'h8000_0008, lat, d, r);
    check("l0_rd_lat",  32'(lat), 32'd1);
    check("l0_rd_data", d, 32'hCAFE_F00D);
    rd(32'h7FFF_FFFC, lat, d, r);
    check("l0_dec_lat",  32'(lat), 32'd1);
    check("l0_dec_resp", {30'd0, r}, 32'd3);
    check("l0_dec_data", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
